// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller:
// FSM states, opcodes, ALU operation codes and datapath mux selects.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_LUI     = 4'd12,
    S_AUIPC   = 4'd13,
    S_HALT    = 4'd14,
    S_ERROR   = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_e;

  // Operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD = 2'd0,
    ALUOP_SUB = 2'd1,
    ALUOP_R   = 2'd2,
    ALUOP_I   = 2'd3
  } alu_op_e;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Datapath control bundle decoded from the current state
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] res_src;
    logic [2:0] imm_src;
  } ctrl_t;

endpackage

// File: rtl/riscv_mc_ctrl_hs_alu_decoder.sv
// ALU decoder: maps the operation class plus funct3/funct7[5] to alu_control.
module riscv_alu_decoder
  import riscv_mc_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output alu_ctrl_e   alu_ctrl
);

  // Decode funct fields; SUB only for R-type, SRA/SRAI both keyed by funct7[5]
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_R, ALUOP_I: begin
        case (funct3)
          3'b000:  alu_ctrl = (alu_op == ALUOP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl_hs.sv
// Multi-cycle RV32I main controller with req/ready memory handshake,
// wait-state watchdog, branch resolver and retired-instruction counter.
// Optional feature macro: RV_MC_HALT_EN (SYSTEM opcode enters HALT).
module riscv_mc_ctrl_hs
  import riscv_mc_pkg::*;
#(
  parameter int unsigned RETIRE_W     = 32,
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                zero,
  input  logic                lt,
  input  logic                ltu,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic [1:0]          alu_srca,
  output logic [1:0]          alu_srcb,
  output logic [1:0]          res_src,
  output logic [2:0]          imm_src,
  output logic [3:0]          alu_control,
  output logic                err,
  output logic                halted,
  output logic [RETIRE_W-1:0] retire_cnt
);

  localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  state_e            state;
  state_e            state_next;
  ctrl_t             ctrl;
  alu_op_e           alu_op;
  alu_ctrl_e         alu_ctrl;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_hit;
  logic              br_valid;
  logic              br_taken;
  logic              retire_inc;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7b5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  riscv_alu_decoder u_alu_dec (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_ctrl (alu_ctrl)
  );

  // Branch resolver: condition from ALU flags; unsupported funct3 flagged invalid
  always_comb begin
    br_valid = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_valid = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  // Next-state and Moore control decode; memory states hold until mem_ready
  always_comb begin
    state_next = state;
    ctrl       = '0;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ctrl.mem_req  = 1'b1;
        ctrl.alu_srca = SRCA_PC;
        ctrl.alu_srcb = SRCB_FOUR;
        ctrl.res_src  = RES_ALURES;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the PC-relative target into ALUOut for BRANCH/JAL
        ctrl.alu_srca = SRCA_OLDPC;
        ctrl.alu_srcb = SRCB_IMM;
        ctrl.imm_src  = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
`ifdef RV_MC_HALT_EN
          OP_SYSTEM:         state_next = S_HALT;
`else
          OP_SYSTEM:         state_next = S_FETCH;
`endif
          default:           state_next = S_ERROR;
        endcase
      end
      S_MEM_ADR: begin
        ctrl.alu_srca = SRCA_RS1;
        ctrl.alu_srcb = SRCB_IMM;
        ctrl.imm_src  = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next    = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.res_src   = RES_MEM;
        ctrl.reg_write = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        ctrl.alu_srca = SRCA_RS1;
        ctrl.alu_srcb = SRCB_RS2;
        alu_op        = ALUOP_R;
        state_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctrl.alu_srca = SRCA_RS1;
        ctrl.alu_srcb = SRCB_IMM;
        ctrl.imm_src  = IMM_I;
        alu_op        = ALUOP_I;
        state_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        // Jumps write the link value oldPC+4 computed here, not ALUOut
        ctrl.reg_write = 1'b1;
        if (opcode == OP_JAL || opcode == OP_JALR) begin
          ctrl.alu_srca = SRCA_OLDPC;
          ctrl.alu_srcb = SRCB_FOUR;
          ctrl.res_src  = RES_ALURES;
        end else begin
          ctrl.res_src  = RES_ALUOUT;
        end
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_srca = SRCA_RS1;
        ctrl.alu_srcb = SRCB_RS2;
        ctrl.res_src  = RES_ALUOUT;
        alu_op        = ALUOP_SUB;
        if (br_valid) begin
          ctrl.pc_write = br_taken;
          state_next    = S_FETCH;
        end else begin
          state_next    = S_ERROR;
        end
      end
      S_JAL: begin
        ctrl.res_src  = RES_ALUOUT;
        ctrl.pc_write = 1'b1;
        state_next    = S_ALU_WB;
      end
      S_JALR: begin
        ctrl.alu_srca = SRCA_RS1;
        ctrl.alu_srcb = SRCB_IMM;
        ctrl.imm_src  = IMM_I;
        ctrl.res_src  = RES_ALURES;
        ctrl.pc_write = 1'b1;
        state_next    = S_ALU_WB;
      end
      S_LUI: begin
        ctrl.imm_src   = IMM_U;
        ctrl.res_src   = RES_IMM;
        ctrl.reg_write = 1'b1;
        state_next     = S_FETCH;
      end
      S_AUIPC: begin
        ctrl.alu_srca = SRCA_OLDPC;
        ctrl.alu_srcb = SRCB_IMM;
        ctrl.imm_src  = IMM_U;
        state_next    = S_ALU_WB;
      end
      S_HALT:  state_next = S_HALT;
      S_ERROR: state_next = S_ERROR;
    endcase

    wait_hit = (MEM_WAIT_MAX != 0) && ctrl.mem_req && !mem_ready && (wait_cnt == WAIT_LAST);
    if (wait_hit) state_next = S_ERROR;
  end

  // Consecutive wait-state counter; any accepted or absent request clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                               wait_cnt <= '0;
    else if (MEM_WAIT_MAX != 0 && ctrl.mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    else                                                    wait_cnt <= '0;
  end

  assign retire_inc = ((state_next == S_FETCH) && (state != S_FETCH)) ||
                      ((state_next == S_HALT)  && (state != S_HALT));

  // Retired-instruction counter, wraps naturally at 2^RETIRE_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            retire_cnt <= '0;
    else if (retire_inc) retire_cnt <= retire_cnt + 1'b1;
  end

  // Output stage: reset forces every output low in the same cycle
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_srca    = '0;
    alu_srcb    = '0;
    res_src     = '0;
    imm_src     = '0;
    alu_control = '0;
    err         = 1'b0;
    if (rst) begin
      mem_req     = ctrl.mem_req;
      mem_write   = ctrl.mem_write;
      adr_src     = ctrl.adr_src;
      ir_write    = ctrl.ir_write;
      pc_write    = ctrl.pc_write;
      reg_write   = ctrl.reg_write;
      alu_srca    = ctrl.alu_srca;
      alu_srcb    = ctrl.alu_srcb;
      res_src     = ctrl.res_src;
      imm_src     = ctrl.imm_src;
      alu_control = 4'(alu_ctrl);
      err         = (state == S_ERROR);
    end
  end

`ifdef RV_MC_HALT_EN
  assign halted = rst && (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
